wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back stage plus integer register file, fed directly by the MEM/WB
//  pipeline register outputs. Selects the write-back value (load data, ALU
//  result or immediate), commits it to a 32-entry register file on the clock
//  edge, and serves two decode-stage read ports with same-cycle write-through
//  bypass. Also keeps a retired-write counter and last-write trace for debug.
// PARAMETERS
//  DATA_W  32  register / datapath width
//  ADDR_W  5   register index width (2**ADDR_W entries, entry 0 hardwired 0)
//  CNT_W   32  width of retired-write counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  i_ddata      in   DATA_W  load data from MEM/WB
//  i_aluo       in   DATA_W  ALU result from MEM/WB
//  i_imm        in   DATA_W  immediate from MEM/WB
//  i_rd         in   ADDR_W  destination register index
//  i_mem_t_reg  in   1       1 = write back load data
//  i_reg_w      in   1       1 = register write requested
//  i_rd_in      in   1       1 = write back immediate (overrides i_mem_t_reg)
//  i_rs1        in   ADDR_W  read port 1 index (decode stage)
//  i_rs2        in   ADDR_W  read port 2 index (decode stage)
//  o_rs1_data   out  DATA_W  read port 1 data (combinational)
//  o_rs2_data   out  DATA_W  read port 2 data (combinational)
//  o_wb_data    out  DATA_W  selected write-back value (combinational)
//  o_wb_en      out  1       effective write enable (combinational)
//  o_retire_cnt out  CNT_W   count of committed writes (registered)
//  o_last_rd    out  ADDR_W  index of most recent committed write (registered)
//  o_last_data  out  DATA_W  data of most recent committed write (registered)
// BEHAVIOUR
//  - WB select: i_rd_in=1 -> i_imm; else i_mem_t_reg=1 -> i_ddata; else i_aluo.
//  - o_wb_en = i_reg_w & (i_rd != 0). Writes to x0 are discarded entirely.
//  - Commit: on posedge clk with o_wb_en=1, reg[i_rd] <= o_wb_data. Latency 1.
//  - Read: o_rsN_data = 0 if i_rsN==0; else o_wb_data if o_wb_en & i_rsN==i_rd
//    (write-through bypass, same cycle); else reg[i_rsN]. Both ports are
//    independent; both may bypass in the same cycle.
//  - Counter: o_retire_cnt increments by 1 on each posedge with o_wb_en=1;
//    wraps from 2**CNT_W-1 to 0 without a flag. i_reg_w with rd=0 not counted.
//  - Trace: on each commit, o_last_rd <= i_rd, o_last_data <= o_wb_data;
//    held otherwise.
//  - Reset (rst_n=0, asynchronous, any time incl. mid-stream): all registers
//    1..2**ADDR_W-1 -> 0, o_retire_cnt -> 0, o_last_rd -> 0, o_last_data -> 0.
//    While held in reset no commit occurs; reads return 0 for stored values but
//    bypass still forwards o_wb_data when o_wb_en=1 (combinational path).
//  - First edge after rst_n deasserts commits normally.
//  - No X propagation: all selects fully decoded; undriven selects default ALU.
// TESTING
//  1 Reset: rst_n=0 then 1; read all 32 indices -> 0; retire_cnt=0.
//  2 Source select: rd=5, reg_w=1 with (rd_in,mem_t_reg)=00/01/10/11 and
//    aluo=0x11, ddata=0x22, imm=0x33 -> x5 holds 0x11,0x22,0x33,0x33.
//  3 x0 guard: rd=0, reg_w=1, aluo=0xDEADBEEF -> rs1=0 reads 0, o_wb_en=0,
//    retire_cnt unchanged.
//  4 Bypass: rd=7 writing 0xA5A5A5A5, rs1=rs2=7 same cycle -> both outputs
//    0xA5A5A5A5 before edge; after edge stored value matches.
//  5 Async reset mid-stream: write x3=0x1234, pulse rst_n low between edges
//    -> x3 reads 0 immediately, retire_cnt=0, last_rd=0, no spurious commit.
//  6 Counter wrap (CNT_W=4): 17 commits -> retire_cnt=1; last_rd/last_data
//    match final commit.

Source files
------------

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// wb_regfile : write-back select, integer register file with write-through
//              bypass, retired-write counter and last-write trace.
// Revision   : 1.0
// ============================================================================
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_ddata,
  input  logic [DATA_W-1:0] i_aluo,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic              i_mem_t_reg,
  input  logic              i_reg_w,
  input  logic              i_rd_in,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_wb_en,
  output logic [CNT_W-1:0]  o_retire_cnt,
  output logic [ADDR_W-1:0] o_last_rd,
  output logic [DATA_W-1:0] o_last_data
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_en;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_rd_q, last_rd_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;

  // Immediate has priority over load data; anything else falls back to ALU.
  always_comb begin
    w_wb_data = i_aluo;
    if (i_rd_in == 1'b1)
      w_wb_data = i_imm;
    else if (i_mem_t_reg == 1'b1)
      w_wb_data = i_ddata;
  end

  assign w_wb_en = (i_reg_w == 1'b1) && (i_rd != '0);

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = regs_q[idx];
    if (idx == '0)
      val = '0;
    else if (w_wb_en && (idx == i_rd))
      val = w_wb_data;
    return val;
  endfunction

  assign o_rs1_data = read_port(i_rs1);
  assign o_rs2_data = read_port(i_rs2);

  // Entry 0 is reset but never written, since w_wb_en excludes rd == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else if (w_wb_en) begin
      regs_q[i_rd] <= w_wb_data;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    last_rd_d   = last_rd_q;
    last_data_d = last_data_q;
    if (w_wb_en) begin
      cnt_d       = cnt_q + CNT_W'(1);
      last_rd_d   = i_rd;
      last_data_d = w_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      last_rd_q   <= '0;
      last_data_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      last_rd_q   <= last_rd_d;
      last_data_q <= last_data_d;
    end
  end

  assign o_wb_data    = w_wb_data;
  assign o_wb_en      = w_wb_en;
  assign o_retire_cnt = cnt_q;
  assign o_last_rd    = last_rd_q;
  assign o_last_data  = last_data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// tb_wb_regfile : scoreboard bench for wb_regfile (counter width 4 so that
//                 wrap-around is reachable).
// Revision      : 1.0
// ============================================================================
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_ddata = '0, i_aluo = '0, i_imm = '0;
  logic [AW-1:0] i_rd = '0, i_rs1 = '0, i_rs2 = '0;
  logic          i_mem_t_reg = 1'b0, i_reg_w = 1'b0, i_rd_in = 1'b0;
  logic [DW-1:0] o_rs1_data, o_rs2_data, o_wb_data, o_last_data;
  logic          o_wb_en;
  logic [CW-1:0] o_retire_cnt;
  logic [AW-1:0] o_last_rd;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ddata     (i_ddata),
    .i_aluo      (i_aluo),
    .i_imm       (i_imm),
    .i_rd        (i_rd),
    .i_mem_t_reg (i_mem_t_reg),
    .i_reg_w     (i_reg_w),
    .i_rd_in     (i_rd_in),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .o_rs1_data  (o_rs1_data),
    .o_rs2_data  (o_rs2_data),
    .o_wb_data   (o_wb_data),
    .o_wb_en     (o_wb_en),
    .o_retire_cnt(o_retire_cnt),
    .o_last_rd   (o_last_rd),
    .o_last_data (o_last_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_reg [32];
  logic [CW-1:0] m_cnt;
  logic [AW-1:0] m_last_rd;
  logic [DW-1:0] m_last_data;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;
  wr_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_cnt       = '0;
    m_last_rd   = '0;
    m_last_data = '0;
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] idx, input logic en,
                                           input logic [AW-1:0] rd, input logic [DW-1:0] wb);
    if (idx == 0) return '0;
    if (en && idx == rd) return wb;
    return m_reg[idx];
  endfunction

  // One write-back cycle: check combinational outputs before the edge, then
  // drain the scoreboard by reading committed entries back after the edge.
  task automatic drive(input logic [AW-1:0] rd, input logic reg_w, input logic rd_in,
                       input logic mem_t, input logic [DW-1:0] alu, input logic [DW-1:0] dd,
                       input logic [DW-1:0] imm, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2);
    logic [DW-1:0] ewb;
    logic          een;
    @(negedge clk);
    i_rd = rd; i_reg_w = reg_w; i_rd_in = rd_in; i_mem_t_reg = mem_t;
    i_aluo = alu; i_ddata = dd; i_imm = imm; i_rs1 = rs1; i_rs2 = rs2;
    if (rd_in) ewb = imm;
    else if (mem_t) ewb = dd;
    else ewb = alu;
    een = reg_w && (rd != 0);
    #1;
    check("wb_data", 64'(o_wb_data), 64'(ewb));
    check("wb_en", 64'(o_wb_en), 64'(een));
    check("rs1_pre", 64'(o_rs1_data), 64'(m_read(rs1, een, rd, ewb)));
    check("rs2_pre", 64'(o_rs2_data), 64'(m_read(rs2, een, rd, ewb)));
    if (een) sb_q.push_back('{rd: rd, data: ewb});
    @(posedge clk);
    #1;
    if (een) begin
      m_reg[rd]   = ewb;
      m_cnt       = m_cnt + 1'b1;
      m_last_rd   = rd;
      m_last_data = ewb;
    end
    i_reg_w = 1'b0;
    check("retire_cnt", 64'(o_retire_cnt), 64'(m_cnt));
    while (sb_q.size() > 0) begin
      wr_t e;
      e = sb_q.pop_front();
      i_rs1 = e.rd;
      #1;
      check("commit", 64'(o_rs1_data), 64'(e.data));
      check("last_rd", 64'(o_last_rd), 64'(e.rd));
      check("last_data", 64'(o_last_data), 64'(e.data));
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 32; i++) begin
      i_rs1 = AW'(i);
      i_rs2 = AW'(31 - i);
      #1;
      check("rst_rs1", 64'(o_rs1_data), 64'd0);
      check("rst_rs2", 64'(o_rs2_data), 64'd0);
    end
    check("rst_cnt", 64'(o_retire_cnt), 64'd0);
    check("rst_last_rd", 64'(o_last_rd), 64'd0);
    check("rst_last_data", 64'(o_last_data), 64'd0);

    // Source select on x5
    drive(5, 1, 0, 0, 32'h11, 32'h22, 32'h33, 5, 0);
    drive(5, 1, 0, 1, 32'h11, 32'h22, 32'h33, 5, 0);
    drive(5, 1, 1, 0, 32'h11, 32'h22, 32'h33, 5, 0);
    drive(5, 1, 1, 1, 32'h11, 32'h22, 32'h33, 5, 5);

    // x0 guard
    drive(0, 1, 0, 0, 32'hDEADBEEF, 32'h0, 32'h0, 0, 5);

    // Dual bypass
    drive(7, 1, 0, 0, 32'hA5A5A5A5, 32'h0, 32'h0, 7, 7);

    // Read without write request, and a random mix
    drive(9, 0, 0, 0, 32'h99, 32'h0, 32'h0, 9, 7);
    for (int k = 0; k < 12; k++)
      drive(AW'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));

    // Asynchronous reset mid-stream
    drive(3, 1, 0, 0, 32'h1234, 32'h0, 32'h0, 3, 0);
    @(negedge clk);
    i_reg_w = 1'b0;
    i_rs1   = 3;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_x3", 64'(o_rs1_data), 64'd0);
    check("arst_cnt", 64'(o_retire_cnt), 64'd0);
    check("arst_last_rd", 64'(o_last_rd), 64'd0);
    check("arst_last_data", 64'(o_last_data), 64'd0);
    i_rd = 9; i_reg_w = 1'b1; i_rd_in = 1'b0; i_mem_t_reg = 1'b0;
    i_aluo = 32'hCAFEF00D; i_rs1 = 9; i_rs2 = 3;
    #1;
    check("arst_bypass", 64'(o_rs1_data), 64'hCAFEF00D);
    check("arst_rs2", 64'(o_rs2_data), 64'd0);
    @(posedge clk);
    #1;
    i_reg_w = 1'b0;
    #1;
    check("arst_nocommit", 64'(o_rs1_data), 64'd0);
    check("arst_nocnt", 64'(o_retire_cnt), 64'd0);
    #1;
    rst_n = 1'b1;

    // Counter wrap: 17 commits from zero on a 4-bit counter
    for (int k = 0; k < 17; k++)
      drive(AW'((k % 31) + 1), 1, 0, 0, $urandom, 32'h0, 32'h0, AW'((k % 31) + 1), 0);
    check("wrap_cnt", 64'(o_retire_cnt), 64'd1);
    check("wrap_last_rd", 64'(o_last_rd), 64'(m_last_rd));
    check("wrap_last_data", 64'(o_last_data), 64'(m_last_data));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
